// File: rtl/data_mem_pkg.sv
// Shared types and limits for the dual-address data memory and its clear sequencer.
package data_mem_pkg;
    typedef enum logic {MS_IDLE, MS_CLEAR} mem_state_t;
    localparam int READ_LAT_MAX = 1;
endpackage

// File: rtl/data_mem_clear_fsm.sv
// Clear sequencer: walks every address once after reset or on request, holding busy throughout.
module data_mem_clear_fsm
    import data_mem_pkg::*;
#(
    parameter int A = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_req,
    output logic         busy,
    output logic [A-1:0] clr_addr
);

    mem_state_t   state, state_nxt;
    logic [A-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MS_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            MS_IDLE: begin
                if (clear_req) begin
                    state_nxt = MS_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            MS_CLEAR: begin
                // Requests arriving mid-clear are dropped, not queued.
                cnt_nxt = cnt + 1'b1;
                if (cnt == '1)
                    state_nxt = MS_IDLE;
            end
            default: state_nxt = MS_IDLE;
        endcase
    end

    assign busy     = (state == MS_CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/data_mem_dp.sv
// 1R/1W data RAM with built-in clear sequencer and selectable 0/1-cycle read latency.
module data_mem_dp
    import data_mem_pkg::*;
#(
    parameter int           W         = 8,
    parameter int           A         = 8,
    parameter int           READ_LAT  = 1,
    parameter logic [W-1:0] CLEAR_VAL = '0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         ClearReq,
    output logic         Busy,
    input  logic         WriteEn,
    input  logic [A-1:0] WriteAddr,
    input  logic [W-1:0] DataIn,
    input  logic         ReadEn,
    input  logic [A-1:0] ReadAddr,
    output logic [W-1:0] DataOut,
    output logic         DataValid
);

    localparam int DEPTH = 2 ** A;

    logic [W-1:0] core [0:DEPTH-1];
    logic         busy;
    logic [A-1:0] clr_addr;
    logic         mem_we;
    logic [A-1:0] mem_addr;
    logic [W-1:0] mem_din;
    logic         rd_ok;

    data_mem_clear_fsm #(.A(A)) u_clear (
        .clk       (Clk),
        .reset     (Reset),
        .clear_req (ClearReq),
        .busy      (busy),
        .clr_addr  (clr_addr)
    );

    assign Busy = busy;

    // The sequencer owns the single write port while clearing.
    assign mem_we   = busy | WriteEn;
    assign mem_addr = busy ? clr_addr  : WriteAddr;
    assign mem_din  = busy ? CLEAR_VAL : DataIn;
    assign rd_ok    = ReadEn & ~busy;

    always_ff @(posedge Clk) begin
        if (mem_we)
            core[mem_addr] <= mem_din;
    end

    generate
        if (READ_LAT == 0) begin : g_lat0
            assign DataOut   = core[ReadAddr];
            assign DataValid = rd_ok;
        end else if (READ_LAT == READ_LAT_MAX) begin : g_lat1
            logic [W-1:0] dout;
            logic         dvalid;

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    dout   <= '0;
                    dvalid <= 1'b0;
                end else if (rd_ok) begin
                    dvalid <= 1'b1;
                    // Write-first: a same-cycle write to the read address is forwarded.
                    dout   <= (WriteEn && WriteAddr == ReadAddr) ? DataIn : core[ReadAddr];
                end else begin
                    dvalid <= 1'b0;
                end
            end

            assign DataOut   = dout;
            assign DataValid = dvalid;
        end else begin : g_bad_lat
            $error("data_mem_dp: READ_LAT must be 0 or 1");
        end
    endgenerate

endmodule

// File: tb/tb_data_mem_dp.sv
// Directed bench: drives one latency-1 and one latency-0 instance in lockstep.
module tb_data_mem_dp;

    logic       Clk = 1'b0;
    logic       Reset, ClearReq, WriteEn, ReadEn;
    logic [3:0] WriteAddr, ReadAddr;
    logic [7:0] DataIn;
    logic       busy1, busy0, dv1, dv0;
    logic [7:0] do1, do0;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    data_mem_dp #(.W(8), .A(4), .READ_LAT(1), .CLEAR_VAL(8'hA5)) u_lat1 (
        .Clk(Clk), .Reset(Reset), .ClearReq(ClearReq), .Busy(busy1),
        .WriteEn(WriteEn), .WriteAddr(WriteAddr), .DataIn(DataIn),
        .ReadEn(ReadEn), .ReadAddr(ReadAddr), .DataOut(do1), .DataValid(dv1)
    );

    data_mem_dp #(.W(8), .A(4), .READ_LAT(0), .CLEAR_VAL(8'hA5)) u_lat0 (
        .Clk(Clk), .Reset(Reset), .ClearReq(ClearReq), .Busy(busy0),
        .WriteEn(WriteEn), .WriteAddr(WriteAddr), .DataIn(DataIn),
        .ReadEn(ReadEn), .ReadAddr(ReadAddr), .DataOut(do0), .DataValid(dv0)
    );

    typedef struct {
        logic       we;
        logic [3:0] waddr;
        logic [7:0] din;
        logic       re;
        logic [3:0] raddr;
        logic       ev0;
        logic [7:0] ed0;
        logic       ev1;
        logic [7:0] ed1;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    // Called just after a posedge: lat0 checked mid-cycle, lat1 after the next edge.
    task automatic apply_vec(input vec_t v, input string tag);
        WriteEn   = v.we;
        WriteAddr = v.waddr;
        DataIn    = v.din;
        ReadEn    = v.re;
        ReadAddr  = v.raddr;
        @(negedge Clk);
        chk($sformatf("%s lat0 valid", tag), dv0, v.ev0);
        if (v.ev0) chk($sformatf("%s lat0 data", tag), do0, v.ed0);
        step;
        chk($sformatf("%s lat1 valid", tag), dv1, v.ev1);
        if (v.ev1) chk($sformatf("%s lat1 data", tag), do1, v.ed1);
        WriteEn = 1'b0;
        ReadEn  = 1'b0;
    endtask

    task automatic read_chk(input logic [3:0] a, input logic [7:0] exp, input string tag);
        vec_t v;
        v = '{1'b0, 4'd0, 8'h00, 1'b1, a, 1'b1, exp, 1'b1, exp};
        apply_vec(v, tag);
    endtask

    // Counts Busy cycles from the current sample; optionally holds ClearReq,
    // throws ignored traffic at the memory, or pulses Reset on busy cycle reset_at.
    task automatic count_busy(output int n1, output int n0,
                              input bit hold_clr, input bit stray_io, input int reset_at);
        n1 = 0;
        n0 = 0;
        for (int k = 0; k < 100; k++) begin
            if (!busy1 && !busy0) break;
            if (busy1) n1++;
            if (busy0) n0++;
            Reset    = (reset_at != 0 && n1 == reset_at);
            ClearReq = hold_clr;
            if (stray_io) begin
                WriteEn = 1'b1; WriteAddr = 4'd3; DataIn = 8'h55;
                ReadEn  = 1'b1; ReadAddr  = 4'd3;
            end
            @(negedge Clk);
            if (stray_io) chk("busy lat0 valid", dv0, 1'b0);
            step;
            if (stray_io) begin
                chk("busy lat1 valid", dv1, 1'b0);
                chk("busy lat1 hold", do1, 8'h77);
            end
        end
        Reset = 1'b0; ClearReq = 1'b0; WriteEn = 1'b0; ReadEn = 1'b0;
    endtask

    initial begin
        int n1, n0;

        vecs[0] = '{1'b1, 4'd5,  8'h3C, 1'b0, 4'd0,  1'b0, 8'h00, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd5,  1'b1, 8'h3C, 1'b1, 8'h3C};
        vecs[2] = '{1'b1, 4'd7,  8'h11, 1'b1, 4'd7,  1'b1, 8'hA5, 1'b1, 8'h11};
        vecs[3] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd7,  1'b1, 8'h11, 1'b1, 8'h11};
        vecs[4] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd0,  1'b1, 8'hA5, 1'b1, 8'hA5};
        vecs[5] = '{1'b1, 4'd15, 8'h00, 1'b1, 4'd15, 1'b1, 8'hA5, 1'b1, 8'h00};
        vecs[6] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 1'b1, 8'h00, 1'b1, 8'h00};
        vecs[7] = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  1'b0, 8'h00, 1'b0, 8'h00};

        Reset = 1'b1; ClearReq = 1'b0; WriteEn = 1'b0; ReadEn = 1'b0;
        WriteAddr = '0; ReadAddr = '0; DataIn = '0;
        step;
        Reset = 1'b0;
        chk("reset busy lat1", busy1, 1'b1);
        chk("reset busy lat0", busy0, 1'b1);
        chk("reset valid lat1", dv1, 1'b0);
        chk("reset valid lat0", dv0, 1'b0);
        chk("reset data lat1", do1, 8'h00);

        count_busy(n1, n0, 1'b0, 1'b0, 0);
        chk("init clear cycles lat1", n1, 16);
        chk("init clear cycles lat0", n0, 16);

        for (int a = 0; a < 16; a++)
            read_chk(4'(a), 8'hA5, $sformatf("init rd %0d", a));

        for (int i = 0; i < 8; i++)
            apply_vec(vecs[i], $sformatf("vec %0d", i));

        // Write 0x77@3, prove it landed, then a held ClearReq with ignored traffic.
        apply_vec('{1'b1, 4'd3, 8'h77, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0, 8'h00}, "wr 77");
        read_chk(4'd3, 8'h77, "rd 77");
        ClearReq = 1'b1;
        step;
        count_busy(n1, n0, 1'b1, 1'b1, 0);
        chk("req clear cycles lat1", n1, 16);
        chk("req clear cycles lat0", n0, 16);
        chk("no re-clear lat1", busy1, 1'b0);
        read_chk(4'd3, 8'hA5, "post clear rd3");
        read_chk(4'd15, 8'hA5, "post clear rd15");

        // Reset on the ninth busy cycle restarts the sweep.
        ClearReq = 1'b1;
        step;
        ClearReq = 1'b0;
        count_busy(n1, n0, 1'b0, 1'b0, 9);
        chk("restart cycles lat1", n1, 25);
        chk("restart cycles lat0", n0, 25);
        chk("restart data lat1", do1, 8'h00);

        // Write and ClearReq together in IDLE: clear begins the following cycle.
        WriteEn = 1'b1; WriteAddr = 4'd9; DataIn = 8'h5A; ClearReq = 1'b1;
        step;
        WriteEn = 1'b0; ClearReq = 1'b0;
        chk("wr+clr busy lat1", busy1, 1'b1);
        count_busy(n1, n0, 1'b0, 1'b0, 0);
        chk("wr+clr cycles lat1", n1, 16);
        chk("wr+clr cycles lat0", n0, 16);
        read_chk(4'd9, 8'hA5, "wr+clr rd9");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
